heater_window_driver: RTL and testbench
=======================================

Name: heater_window_driver

Overview:
- Time-proportioning output stage that sits directly downstream of the PID-response-to-time converter.
- Consumes the converter's 25-bit on-time (in clock cycles) and drives the heater relay/SSR enable.
- The output is high for on-time cycles at the start of each fixed-length control window, then low for the rest of the window.
- Flags the loop as stale and forces the heater off when the upstream stops supplying updates.

Parameters:
- PERIOD, 25'd20_000_000, control window length in CLK cycles (must be >= 2).
- MIN_ON, 25'd50_000, on-times that are nonzero but below this are treated as 0 (relay protection).
- STALE_WINDOWS, 4'd3, consecutive window starts with no new TIME_VALID before STALE asserts.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- EN  in  1  run enable; low = idle, heater off.
- TIME_VALUE  in  25  requested on-time in cycles, from the converter.
- TIME_VALID  in  1  one-cycle strobe: TIME_VALUE is valid (top level drives it as converter EN delayed one cycle).
- HEATER_ON  out  1  registered heater drive.
- WINDOW_START  out  1  registered one-cycle pulse at each window start; used upstream to schedule the next PID update.
- STALE  out  1  registered; high = upstream updates missing, heater forced off.

Behaviour:
- Reset (RST_N low, immediate): HEATER_ON=0, WINDOW_START=0, STALE=0, state=IDLE, cnt=0, pending=0, fresh=0, stale_cnt=0, on_time=0.
- Pending latch, independent of EN:
  - TIME_VALID=1 at an edge: pending<=TIME_VALUE, fresh<=1, STALE<=0.
  - A new value is never applied mid-window.
  - If TIME_VALID coincides with a window-start edge, that window uses the old pending value; the new value applies from the next window; fresh stays 1.
- Clamp, applied when loading on_time: value >= PERIOD -> PERIOD (full on); 0 < value < MIN_ON -> 0; otherwise unchanged.
- FSM states:
  - IDLE: EN sampled 1 -> window start, go to RUN.
  - RUN: EN sampled 0 -> IDLE.
- Window start edge (IDLE with EN=1, or RUN with cnt==PERIOD-1 and EN=1):
  - cnt<=0, WINDOW_START<=1.
  - Stale check: fresh=1 -> stale_cnt<=0, fresh<=0; else stale_cnt<=stale_cnt+1 (saturating). When this increment reaches STALE_WINDOWS, STALE<=1.
  - on_time<=0 if STALE is, or becomes, 1; else clamp(pending).
  - HEATER_ON<=(loaded on_time != 0).
- Other RUN edges:
  - cnt<=cnt+1, WINDOW_START<=0.
  - HEATER_ON<=((cnt+1) < on_time) and not STALE.
  - Heater is high for exactly on_time cycles, starting the cycle after the window-start edge.
- Leaving RUN (EN sampled 0):
  - HEATER_ON<=0 and WINDOW_START<=0 on that edge; cnt<=0; stale_cnt<=0; STALE<=0.
  - pending and fresh are retained.
- Re-enable always begins a fresh full window; the partial window is never resumed.
- on_time==PERIOD: HEATER_ON stays continuously high across window boundaries, with no glitch.
- STALE asserting mid-window is impossible: it changes only at window starts; TIME_VALID clears it.

Decomposition:
- Shared package heater_pkg holds:
  - TIME_W=25.
  - RUN/IDLE state encoding.
  - clamp function for on_time.
- One natural sub-module: window_counter, which holds the cnt register, PERIOD wrap and the wrap-pulse output. The FSM, latch and stale logic stay in the top module.

Test Plan (PERIOD=100, MIN_ON=5, STALE_WINDOWS=3):
- Reset: hold RST_N=0 with EN=1 -> all outputs 0; release -> WINDOW_START pulses on the first edge, with pending=0 giving HEATER_ON=0.
- TIME_VALID with TIME_VALUE=30, then EN=1 -> WINDOW_START every 100 cycles; HEATER_ON high for 30 cycles, low for 70, repeating; TIME_VALID is re-strobed each window.
- Clamping: TIME_VALUE=150 -> HEATER_ON continuously high across 2 windows; TIME_VALUE=3 -> HEATER_ON never high; TIME_VALUE=5 -> high for 5 cycles.
- Mid-window update: 30 active, TIME_VALID with 60 at cnt=10 -> current window on for 30 cycles, next window on for 60 cycles. A strobe coincident with WINDOW_START also takes effect only on the following window.
- EN dropped at cnt=12 of a 30-cycle on-phase -> HEATER_ON low on the next edge, no WINDOW_START. EN reasserted -> new window with full 30-cycle on-phase.
- Staleness: load 30 once, then no TIME_VALID -> windows 1-3 on for 30 cycles; at start of window 4 STALE=1 and HEATER_ON stays 0. TIME_VALID with 40 -> STALE=0 next edge, heater still off until the next window start, then on for 40 cycles.

Source files
------------

// File: rtl/heater_pkg.sv
// Shared types, widths and the on-time clamp for the heater window driver.
package heater_pkg;

    localparam int TIME_W = 25;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Full-on above the window length, and short pulses are dropped to protect the relay.
    function automatic logic [TIME_W-1:0] clamp_on_time(
        input logic [TIME_W-1:0] value,
        input logic [TIME_W-1:0] period,
        input logic [TIME_W-1:0] min_on
    );
        logic [TIME_W-1:0] result;
        if (value >= period) begin
            result = period;
        end else if ((value != {TIME_W{1'b0}}) && (value < min_on)) begin
            result = {TIME_W{1'b0}};
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/heater_window_driver_window_counter.sv
// Position-in-window counter; flags the last cycle so the top can start the next window.
module window_counter
    import heater_pkg::*;
#(
    parameter logic [TIME_W-1:0] PERIOD = 25'd20_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance,
    output logic [TIME_W-1:0] cnt,
    output logic              cnt_last
);

    logic [TIME_W-1:0] cnt_r;
    logic [TIME_W-1:0] cnt_next_s;
    logic              cnt_last_r;

    // Next count: hold at zero when not running, wrap after the last cycle of a window.
    always_comb begin
        cnt_next_s = {TIME_W{1'b0}};
        if (!advance) begin
            cnt_next_s = {TIME_W{1'b0}};
        end else if (cnt_last_r) begin
            cnt_next_s = {TIME_W{1'b0}};
        end else begin
            cnt_next_s = cnt_r + 25'd1;
        end
    end

    // Count register plus a registered end-of-window flag tracking it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= {TIME_W{1'b0}};
            cnt_last_r <= 1'b0;
        end else begin
            cnt_r      <= cnt_next_s;
            cnt_last_r <= (cnt_next_s == (PERIOD - 25'd1));
        end
    end

    assign cnt      = cnt_r;
    assign cnt_last = cnt_last_r;

endmodule

// File: rtl/heater_window_driver.sv
// Time-proportioning heater drive: on for the requested cycles at the start of each
// window, with a staleness guard that forces the heater off when updates stop.
module heater_window_driver
    import heater_pkg::*;
#(
    parameter logic [TIME_W-1:0] PERIOD        = 25'd20_000_000,
    parameter logic [TIME_W-1:0] MIN_ON        = 25'd50_000,
    parameter logic [3:0]        STALE_WINDOWS = 4'd3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [TIME_W-1:0] time_value,
    input  logic              time_valid,
    output logic              heater_on,
    output logic              window_start,
    output logic              stale
);

    state_e            state_r;
    logic [TIME_W-1:0] pending_r;
    logic [TIME_W-1:0] on_time_r;
    logic              fresh_r;
    logic [3:0]        stale_cnt_r;
    logic              heater_on_r;
    logic              window_start_r;
    logic              stale_r;

    logic [TIME_W-1:0] cnt_s;
    logic              cnt_last_s;
    logic              advance_s;
    logic              win_start_s;
    logic              stale_win_s;
    logic [3:0]        stale_cnt_inc_s;
    logic [TIME_W-1:0] on_load_s;
    logic [TIME_W-1:0] cnt_inc_s;

    window_counter #(
        .PERIOD(PERIOD)
    ) u_window_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (advance_s),
        .cnt     (cnt_s),
        .cnt_last(cnt_last_s)
    );

    // Window-start decode, stale evaluation and the on-time to load for the new window.
    always_comb begin
        advance_s       = 1'b0;
        win_start_s     = 1'b0;
        stale_win_s     = 1'b0;
        stale_cnt_inc_s = 4'd0;
        on_load_s       = {TIME_W{1'b0}};
        cnt_inc_s       = cnt_s + 25'd1;

        case (state_r)
            ST_IDLE: begin
                advance_s   = 1'b0;
                win_start_s = en;
            end
            ST_RUN: begin
                advance_s   = en;
                win_start_s = en && cnt_last_s;
            end
            default: begin
                advance_s   = 1'b0;
                win_start_s = 1'b0;
            end
        endcase

        if (stale_cnt_r == 4'hF) begin
            stale_cnt_inc_s = 4'hF;
        end else begin
            stale_cnt_inc_s = stale_cnt_r + 4'd1;
        end

        if (fresh_r) begin
            stale_win_s = 1'b0;
        end else begin
            stale_win_s = stale_r || (stale_cnt_inc_s >= STALE_WINDOWS);
        end

        if (stale_win_s) begin
            on_load_s = {TIME_W{1'b0}};
        end else begin
            on_load_s = clamp_on_time(pending_r, PERIOD, MIN_ON);
        end
    end

    // Run/idle FSM with registered outputs; a TIME_VALID strobe overrides the latch
    // fields last, so it wins over the window-start fresh/stale updates on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            pending_r      <= {TIME_W{1'b0}};
            on_time_r      <= {TIME_W{1'b0}};
            fresh_r        <= 1'b0;
            stale_cnt_r    <= 4'd0;
            heater_on_r    <= 1'b0;
            window_start_r <= 1'b0;
            stale_r        <= 1'b0;
        end else begin
            if (win_start_s) begin
                state_r        <= ST_RUN;
                window_start_r <= 1'b1;
                on_time_r      <= on_load_s;
                heater_on_r    <= (on_load_s != {TIME_W{1'b0}});
                stale_r        <= stale_win_s;
                if (fresh_r) begin
                    stale_cnt_r <= 4'd0;
                    fresh_r     <= 1'b0;
                end else begin
                    stale_cnt_r <= stale_cnt_inc_s;
                end
            end else if ((state_r == ST_RUN) && en) begin
                window_start_r <= 1'b0;
                heater_on_r    <= (cnt_inc_s < on_time_r) && !stale_r;
            end else begin
                state_r        <= ST_IDLE;
                window_start_r <= 1'b0;
                heater_on_r    <= 1'b0;
                stale_cnt_r    <= 4'd0;
                stale_r        <= 1'b0;
            end

            if (time_valid) begin
                pending_r <= time_value;
                fresh_r   <= 1'b1;
                stale_r   <= 1'b0;
            end else begin
                pending_r <= pending_r;
            end
        end
    end

    assign heater_on    = heater_on_r;
    assign window_start = window_start_r;
    assign stale        = stale_r;

endmodule

// File: tb/tb_heater_window_driver.sv
// Directed bench for heater_window_driver with a 100-cycle window, MIN_ON=5, stale after 3.
module tb_heater_window_driver;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [24:0] time_value;
    logic        time_valid;
    logic        heater_on;
    logic        window_start;
    logic        stale;

    int n_checks = 0;
    int n_fail   = 0;

    heater_window_driver #(
        .PERIOD       (25'd100),
        .MIN_ON       (25'd5),
        .STALE_WINDOWS(4'd3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .time_value  (time_value),
        .time_valid  (time_valid),
        .heater_on   (heater_on),
        .window_start(window_start),
        .stale       (stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs ncyc edges starting with a window-start edge and checks every output each cycle.
    task automatic run_window(input int on_len, input bit exp_stale, input int strobe_at,
                              input logic [24:0] strobe_val, input int ncyc, input string tag);
        bit   st;
        logic exp_h;
        logic exp_ws;
        st = exp_stale;
        for (int k = 0; k < ncyc; k++) begin
            if (k == strobe_at) begin
                time_valid = 1'b1;
                time_value = strobe_val;
            end
            tick();
            time_valid = 1'b0;
            if (k == strobe_at) st = 1'b0;
            exp_h  = (k < on_len);
            exp_ws = (k == 0);
            n_checks++;
            if (heater_on !== exp_h) begin
                n_fail++;
                $display("FAIL %s heater_on k=%0d got %b want %b", tag, k, heater_on, exp_h);
            end
            n_checks++;
            if (window_start !== exp_ws) begin
                n_fail++;
                $display("FAIL %s window_start k=%0d got %b want %b", tag, k, window_start, exp_ws);
            end
            n_checks++;
            if (stale !== st) begin
                n_fail++;
                $display("FAIL %s stale k=%0d got %b want %b", tag, k, stale, st);
            end
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        en         = 1'b1;
        time_valid = 1'b0;
        time_value = 25'd0;
        repeat (3) tick();
        n_checks++;
        if (heater_on !== 1'b0) begin
            n_fail++;
            $display("FAIL reset heater_on got %b want 0", heater_on);
        end
        n_checks++;
        if (window_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset window_start got %b want 0", window_start);
        end
        n_checks++;
        if (stale !== 1'b0) begin
            n_fail++;
            $display("FAIL reset stale got %b want 0", stale);
        end
        rst_n = 1'b1;
        run_window(0, 1'b0, -1, 25'd0, 100, "post_reset");
        en = 1'b0;
        tick();
        n_checks++;
        if ((heater_on !== 1'b0) || (window_start !== 1'b0)) begin
            n_fail++;
            $display("FAIL reset_leave outputs got %b%b want 00", heater_on, window_start);
        end
    endtask

    task automatic test_basic();
        time_valid = 1'b1;
        time_value = 25'd30;
        tick();
        time_valid = 1'b0;
        n_checks++;
        if ((heater_on !== 1'b0) || (window_start !== 1'b0) || (stale !== 1'b0)) begin
            n_fail++;
            $display("FAIL basic_idle outputs got %b%b%b want 000", heater_on, window_start, stale);
        end
        en = 1'b1;
        run_window(30, 1'b0, 50, 25'd30, 100, "basic_w1");
        run_window(30, 1'b0, 50, 25'd30, 100, "basic_w2");
        run_window(30, 1'b0, 50, 25'd150, 100, "basic_w3");
    endtask

    task automatic test_clamp();
        run_window(100, 1'b0, 50, 25'd150, 100, "clamp150_a");
        run_window(100, 1'b0, 50, 25'd3, 100, "clamp150_b");
        run_window(0, 1'b0, 50, 25'd5, 100, "clamp3");
        run_window(5, 1'b0, 50, 25'd30, 100, "clamp5");
    endtask

    task automatic test_mid_window();
        run_window(30, 1'b0, 10, 25'd60, 100, "mid_w1");
        run_window(60, 1'b0, 0, 25'd45, 100, "mid_coinc");
        run_window(45, 1'b0, 50, 25'd30, 100, "mid_after");
    endtask

    task automatic test_en_drop();
        run_window(30, 1'b0, -1, 25'd0, 13, "drop_pre");
        en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if ((heater_on !== 1'b0) || (window_start !== 1'b0) || (stale !== 1'b0)) begin
                n_fail++;
                $display("FAIL en_drop cyc=%0d outputs got %b%b%b want 000",
                         i, heater_on, window_start, stale);
            end
        end
        en = 1'b1;
        run_window(30, 1'b0, 50, 25'd30, 100, "resume");
    endtask

    task automatic test_stale();
        run_window(30, 1'b0, -1, 25'd0, 100, "stale_w1");
        run_window(30, 1'b0, -1, 25'd0, 100, "stale_w2");
        run_window(30, 1'b0, -1, 25'd0, 100, "stale_w3");
        run_window(0, 1'b1, 20, 25'd40, 100, "stale_w4");
        run_window(40, 1'b0, -1, 25'd0, 100, "stale_w5");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_mid_window();
        test_en_drop();
        test_stale();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
